// File: rtl/mips_matmul_main.sv
// mips_matmul_main: single-cycle MIPS-subset datapath running a fixed, fully
// unrolled 3x3 matrix multiply (C = A x B) from an internal instruction ROM.
// The external pc selects the instruction; the core has no branch/PC logic.
// Optional macro RESULT_REG_EN: register the d** result outputs (one cycle later).
module mips_matmul_main #(
   parameter int unsigned DMEM_WORDS = 32,
   parameter int unsigned IMEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic [31:0] d11,
   output logic [31:0] d12,
   output logic [31:0] d13,
   output logic [31:0] d21,
   output logic [31:0] d22,
   output logic [31:0] d23,
   output logic [31:0] d31,
   output logic [31:0] d32,
   output logic [31:0] d33
);

   localparam int unsigned AW         = $clog2(DMEM_WORDS);
   localparam int unsigned PROG_WORDS = 72;
   localparam int unsigned C_BASE     = 18;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_SP2   = 6'h1C;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_MUL   = 6'h02;

   // I-format encoder
   function automatic logic [31:0] enc_i(input logic [5:0] op, input int unsigned rs,
                                         input int unsigned rt, input int unsigned imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   // R-format encoder (shamt always zero)
   function automatic logic [31:0] enc_r(input logic [5:0] op, input int unsigned rs,
                                         input int unsigned rt, input int unsigned rd,
                                         input logic [5:0] fn);
      return {op, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   // Program ROM contents: 18 loads, then nine mul/mul/mul/add/add/sw blocks
   function automatic logic [31:0] rom_word(input int unsigned n);
      int unsigned b, s, i, j;
      logic [31:0] w;
      w = 32'h0;
      b = 0; s = 0; i = 0; j = 0;
      if (n < 18) begin
         // r(n+1) <- word n (A occupies words 0..8, B words 9..17)
         w = enc_i(OP_LW, 0, n + 1, 4 * n);
      end else if (n < PROG_WORDS) begin
         b = (n - 18) / 6;
         s = (n - 18) % 6;
         i = b / 3;
         j = b % 3;
         case (s)
            0, 1, 2: w = enc_r(OP_SP2, 1 + i * 3 + s, 10 + s * 3 + j, 19 + s, FN_MUL);
            3:       w = enc_r(OP_RTYPE, 19, 20, 19, FN_ADD);
            4:       w = enc_r(OP_RTYPE, 19, 21, 19, FN_ADD);
            default: w = enc_i(OP_SW, 0, 19, 4 * (C_BASE + b));
         endcase
      end
      return w;
   endfunction

   // Reset image of data memory: A = 1..9, B = 9..1, everything else 0
   function automatic logic [31:0] dmem_init(input int unsigned k);
      if (k < 9)       return 32'(k + 1);
      else if (k < 18) return 32'(18 - k);
      else             return 32'h0;
   endfunction

   logic [31:0] regs [32];
   logic [31:0] dmem [DMEM_WORDS];

   logic [31:0] instr;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic [31:0] rs_val, rt_val, addr, mem_rdata;
   logic [AW-1:0] widx;
   logic        is_lw, is_sw, is_add, is_mul;
   logic        wb_en;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic        unused_bits;

   assign unused_bits = ^{pc[1:0], instr[10:6]};

   // Instruction fetch from ROM; out-of-program indices read as NOP
   always_comb begin
      instr = 32'h0;
      if (32'(pc[31:2]) < PROG_WORDS && 32'(pc[31:2]) < IMEM_WORDS)
         instr = rom_word(32'(pc[31:2]));
   end

   assign op     = instr[31:26];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];
   assign rd     = instr[15:11];
   assign funct  = instr[5:0];
   assign imm    = instr[15:0];
   assign rs_val = (rs == 5'd0) ? 32'h0 : regs[rs];
   assign rt_val = (rt == 5'd0) ? 32'h0 : regs[rt];

   // Effective word address, wrapped to the data memory depth
   assign addr      = rs_val + {{16{imm[15]}}, imm};
   assign widx      = AW'((addr >> 2) % DMEM_WORDS);
   assign mem_rdata = dmem[widx];

   // Decode and writeback selection
   always_comb begin
      is_lw   = (op == OP_LW);
      is_sw   = (op == OP_SW);
      is_add  = (op == OP_RTYPE) && (funct == FN_ADD);
      is_mul  = (op == OP_SP2) && (funct == FN_MUL);
      wb_en   = 1'b0;
      wb_reg  = 5'd0;
      wb_data = 32'h0;
      if (is_lw) begin
         wb_en   = 1'b1;
         wb_reg  = rt;
         wb_data = mem_rdata;
      end else if (is_add) begin
         wb_en   = 1'b1;
         wb_reg  = rd;
         wb_data = rs_val + rt_val;
      end else if (is_mul) begin
         wb_en   = 1'b1;
         wb_reg  = rd;
         wb_data = rs_val * rt_val;
      end
   end

   // Register file update; r0 is never written
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 32; k++) regs[k] <= 32'h0;
      end else if (wb_en && wb_reg != 5'd0) begin
         regs[wb_reg] <= wb_data;
      end
   end

   // Data memory update; reset reloads operands and clears results
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < int'(DMEM_WORDS); k++) dmem[k] <= dmem_init(32'(k));
      end else if (is_sw) begin
         dmem[widx] <= rt_val;
      end
   end

`ifdef RESULT_REG_EN
   // Registered result view, one cycle behind data memory
   always_ff @(posedge clk) begin
      if (rst) begin
         {d11, d12, d13, d21, d22, d23, d31, d32, d33} <= '0;
      end else begin
         d11 <= dmem[C_BASE + 0]; d12 <= dmem[C_BASE + 1]; d13 <= dmem[C_BASE + 2];
         d21 <= dmem[C_BASE + 3]; d22 <= dmem[C_BASE + 4]; d23 <= dmem[C_BASE + 5];
         d31 <= dmem[C_BASE + 6]; d32 <= dmem[C_BASE + 7]; d33 <= dmem[C_BASE + 8];
      end
   end
`else
   // Combinational result view straight from data memory
   always_comb begin
      d11 = dmem[C_BASE + 0]; d12 = dmem[C_BASE + 1]; d13 = dmem[C_BASE + 2];
      d21 = dmem[C_BASE + 3]; d22 = dmem[C_BASE + 4]; d23 = dmem[C_BASE + 5];
      d31 = dmem[C_BASE + 6]; d32 = dmem[C_BASE + 7]; d33 = dmem[C_BASE + 8];
   end
`endif

endmodule

// File: tb/tb_mips_matmul_main.sv
// tb_mips_matmul_main: directed, table-driven checks of the matmul datapath.
module tb_mips_matmul_main;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic [31:0] d11, d12, d13, d21, d22, d23, d31, d32, d33;
   logic [8:0][31:0] dout;

   int nvec;
   int nerr;

   mips_matmul_main dut (
      .clk(clk), .rst(rst), .pc(pc),
      .d11(d11), .d12(d12), .d13(d13),
      .d21(d21), .d22(d22), .d23(d23),
      .d31(d31), .d32(d32), .d33(d33)
   );

   assign dout = {d33, d32, d31, d23, d22, d21, d13, d12, d11};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [8:0][31:0] ZERO  = '0;
   localparam logic [8:0][31:0] FINAL = {32'd90, 32'd114, 32'd138, 32'd54, 32'd69,
                                         32'd84, 32'd18, 32'd24, 32'd30};
   // After running through pc=200: first five results stored
   localparam logic [8:0][31:0] PART  = {32'd0, 32'd0, 32'd0, 32'd0, 32'd69,
                                         32'd84, 32'd18, 32'd24, 32'd30};
   localparam logic [8:0][31:0] ONLY11 = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                                          32'd0, 32'd0, 32'd0, 32'd30};

   typedef struct {
      string            name;
      logic             rst;
      logic [31:0]      pc_start;
      logic [31:0]      pc_step;
      int               ncyc;
      logic [8:0][31:0] exp;
   } seg_t;

   seg_t segs [9];

   // One clock edge with the given inputs; outputs sampled 1 time unit later
   task automatic step(input logic r, input logic [31:0] p);
      rst = r;
      pc  = p;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [8:0][31:0] exp);
      for (int k = 0; k < 9; k++) begin
         nvec++;
         if (dout[k] !== exp[k]) begin
            nerr++;
            $display("FAIL %s d%0d%0d got %0d expected %0d", name, k / 3 + 1, k % 3 + 1,
                     dout[k], exp[k]);
         end
      end
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      rst  = 1'b1;
      pc   = 32'h0;

      segs[0] = '{"reset",     1'b1, 32'd0,    32'd0, 2,   ZERO};
      segs[1] = '{"run",       1'b0, 32'd0,    32'd4, 100, FINAL};
      segs[2] = '{"pc400",     1'b0, 32'd400,  32'd0, 5,   FINAL};
      segs[3] = '{"pc1020",    1'b0, 32'd1020, 32'd0, 5,   FINAL};
      segs[4] = '{"hold284",   1'b0, 32'd284,  32'd0, 10,  FINAL};
      segs[5] = '{"reset2",    1'b1, 32'd0,    32'd0, 1,   ZERO};
      segs[6] = '{"to200",     1'b0, 32'd0,    32'd4, 51,  PART};
      segs[7] = '{"midreset",  1'b1, 32'd200,  32'd0, 1,   ZERO};
      segs[8] = '{"replay",    1'b0, 32'd0,    32'd4, 80,  FINAL};

      for (int s = 0; s < 9; s++) begin
         for (int c = 0; c < segs[s].ncyc; c++)
            step(segs[s].rst, segs[s].pc_start + 32'(c) * segs[s].pc_step);
         check(segs[s].name, segs[s].exp);
      end

      // First store lands at index 23 (pc=92); nothing visible before it
      step(1'b1, 32'd0);
      for (int c = 0; c < 23; c++) step(1'b0, 32'(4 * c));
      check("pre_sw", ZERO);
      step(1'b0, 32'd92);
`ifdef RESULT_REG_EN
      check("sw_edge", ZERO);
`else
      check("sw_edge", ONLY11);
`endif
      step(1'b0, 32'd96);
      check("sw_next", ONLY11);

      // Misaligned pc 0x66 stands in for 0x64 and must behave identically
      step(1'b0, 32'h66);
      step(1'b0, 32'd104);
      check("pc104", ONLY11);
      for (int p = 108; p <= 284; p += 4) step(1'b0, 32'(p));
      step(1'b0, 32'd288);
      check("misaligned_run", FINAL);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
